// File: rtl/trackletprocessor_div_34s_16s_18s_seq_if.sv
// Operand/result handshake bundle for the sequential signed divider.
//   in_valid/in_ready   : operand handshake (dividend, divisor)
//   out_valid/out_ready : result handshake (quotient, remainder, ovf, div0)
// The master modport is the producer/consumer side. The slave modport is the divider.
interface trackletprocessor_div_34s_16s_18s_seq_if #(
  parameter int DIVIDEND_W = 34,
  parameter int DIVISOR_W  = 16,
  parameter int QUOT_W     = 18
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DIVIDEND_W-1:0] dividend;
  logic signed [DIVISOR_W-1:0]  divisor;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [QUOT_W-1:0]     quotient;
  logic signed [DIVISOR_W-1:0]  remainder;
  logic                         ovf;
  logic                         div0;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, ovf, div0
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, ovf, div0
  );
endinterface

// File: rtl/trackletprocessor_div_34s_16s_18s_seq.sv
// Sequential signed divider. It uses radix-2 restoring division and produces one quotient bit per cycle.
//   ap_clk   : clock, rising edge
//   ap_rst_n : asynchronous active-low reset
//   bus      : slave side of the operand/result handshake interface
// The quotient truncates toward zero and saturates to QUOT_W bits (ovf flags the clip).
// The remainder takes the sign of the dividend. A zero divisor returns the saturated
// quotient in the direction of the dividend sign, with div0=1.
// Latency is DIVIDEND_W+1 edges from the accept edge to out_valid.
module trackletprocessor_div_34s_16s_18s_seq #(
  parameter int DIVIDEND_W = 34,
  parameter int DIVISOR_W  = 16,
  parameter int QUOT_W     = 18
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
  trackletprocessor_div_34s_16s_18s_seq_if.slave bus
);

  localparam int CNT_W = $clog2(DIVIDEND_W);

  localparam logic [DIVIDEND_W-1:0] QPOS_LIM = DIVIDEND_W'((64'd1 << (QUOT_W-1)) - 64'd1);
  localparam logic [DIVIDEND_W-1:0] QNEG_LIM = DIVIDEND_W'(64'd1 << (QUOT_W-1));
  localparam logic [QUOT_W-1:0]     QMAX     = {1'b0, {(QUOT_W-1){1'b1}}};
  localparam logic [QUOT_W-1:0]     QMIN     = {1'b1, {(QUOT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic                  sign_n, sign_d, div0_flag;
  logic [DIVIDEND_W-1:0] nmag, qmag;
  logic [DIVISOR_W-1:0]  dmag, rmag;
  logic [CNT_W-1:0]      cnt;

  logic [DIVISOR_W:0]    trial, diff;
  logic                  ge;
  logic [QUOT_W-1:0]     q_fix;
  logic [DIVISOR_W-1:0]  r_fix;
  logic                  ovf_fix;
  logic                  last_iter;

  assign last_iter = (cnt == CNT_W'(DIVIDEND_W-1));

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus.in_ready = (state == IDLE);
    case (state)
      IDLE: if (bus.in_valid) state_nxt = CALC;
      CALC: if (last_iter)    state_nxt = FIX;
      FIX:                    state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // The partial remainder stays below |divisor| <= 2^15. One extra bit therefore holds
  // the shifted trial value.
  always_comb begin
    trial = {rmag, nmag[DIVIDEND_W-1]};
    diff  = trial - {1'b0, dmag};
    ge    = (trial >= {1'b0, dmag});
  end

  always_comb begin
    q_fix   = '0;
    ovf_fix = 1'b0;
    r_fix   = sign_n ? -rmag : rmag;
    if (div0_flag) begin
      q_fix = sign_n ? QMIN : QMAX;
      r_fix = '0;
    end else if (sign_n ^ sign_d) begin
      if (qmag > QNEG_LIM) begin
        q_fix   = QMIN;
        ovf_fix = 1'b1;
      end else begin
        q_fix = -qmag[QUOT_W-1:0];
      end
    end else begin
      if (qmag > QPOS_LIM) begin
        q_fix   = QMAX;
        ovf_fix = 1'b1;
      end else begin
        q_fix = qmag[QUOT_W-1:0];
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      sign_n        <= 1'b0;
      sign_d        <= 1'b0;
      div0_flag     <= 1'b0;
      nmag          <= '0;
      qmag          <= '0;
      dmag          <= '0;
      rmag          <= '0;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.ovf       <= 1'b0;
      bus.div0      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          sign_n    <= bus.dividend[DIVIDEND_W-1];
          sign_d    <= bus.divisor[DIVISOR_W-1];
          nmag      <= bus.dividend[DIVIDEND_W-1] ? -bus.dividend : bus.dividend;
          dmag      <= bus.divisor[DIVISOR_W-1] ? -bus.divisor : bus.divisor;
          div0_flag <= (bus.divisor == '0);
          rmag      <= '0;
          qmag      <= '0;
          cnt       <= '0;
        end
        CALC: begin
          nmag <= {nmag[DIVIDEND_W-2:0], 1'b0};
          rmag <= ge ? diff[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
          qmag <= {qmag[DIVIDEND_W-2:0], ge};
          cnt  <= cnt + 1'b1;
        end
        FIX: begin
          bus.quotient  <= q_fix;
          bus.remainder <= r_fix;
          bus.ovf       <= ovf_fix;
          bus.div0      <= div0_flag;
          bus.out_valid <= 1'b1;
        end
        DONE: if (bus.out_ready) bus.out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trackletprocessor_div_34s_16s_18s_seq.sv
module tb_trackletprocessor_div_34s_16s_18s_seq;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  trackletprocessor_div_34s_16s_18s_seq_if #(.DIVIDEND_W(34), .DIVISOR_W(16), .QUOT_W(18)) intf ();

  trackletprocessor_div_34s_16s_18s_seq #(.DIVIDEND_W(34), .DIVISOR_W(16), .QUOT_W(18)) dut (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .bus     (intf.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: plain signed integer division (truncates toward zero), then clip.
  task automatic model(input longint n, input longint d,
                       output longint q, output longint r, output longint ov, output longint dz);
    longint qq;
    if (d == 0) begin
      dz = 1; ov = 0; r = 0;
      q  = (n < 0) ? -131072 : 131071;
    end else begin
      dz = 0;
      qq = n / d;
      r  = n % d;
      if (qq > 131071)       begin q = 131071;  ov = 1; end
      else if (qq < -131072) begin q = -131072; ov = 1; end
      else                   begin q = qq;      ov = 0; end
    end
  endtask

  longint got_q, got_r;

  task automatic sample_out();
    got_q = intf.quotient;
    got_r = intf.remainder;
  endtask

  // Run one operation. With hold > 0 the result is backpressured for hold cycles,
  // and an ignored second operand is offered during that time.
  task automatic run_op(input string tag, input longint n, input longint d, input int hold);
    longint eq, er, eo, ez, sq, sr;
    int lat;
    model(n, d, eq, er, eo, ez);
    @(negedge ap_clk);
    check({tag, ":in_ready"}, longint'(intf.in_ready), 1);
    intf.in_valid = 1'b1;
    intf.dividend = n[33:0];
    intf.divisor  = d[15:0];
    @(posedge ap_clk);
    #1;
    intf.in_valid = 1'b0;
    intf.dividend = '1;
    intf.divisor  = '1;
    lat = 0;
    while (!intf.out_valid && lat < 100) begin
      @(posedge ap_clk);
      #1;
      lat++;
    end
    check({tag, ":latency"}, lat, 35);
    sample_out();
    check({tag, ":q"}, got_q, eq);
    check({tag, ":r"}, got_r, er);
    check({tag, ":ovf"}, longint'(intf.ovf), eo);
    check({tag, ":div0"}, longint'(intf.div0), ez);
    if (hold > 0) begin
      sq = got_q; sr = got_r;
      for (int i = 0; i < hold; i++) begin
        @(negedge ap_clk);
        intf.in_valid = (i == 3);
        intf.dividend = 34'sd999;
        intf.divisor  = 16'sd3;
        @(posedge ap_clk);
        #1;
        intf.in_valid = 1'b0;
        sample_out();
        check({tag, ":hold_valid"}, longint'(intf.out_valid), 1);
        check({tag, ":hold_ready"}, longint'(intf.in_ready), 0);
        check({tag, ":hold_q"}, got_q, sq);
        check({tag, ":hold_r"}, got_r, sr);
      end
    end
    @(negedge ap_clk);
    intf.out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    intf.out_ready = 1'b0;
    check({tag, ":valid_drop"}, longint'(intf.out_valid), 0);
    check({tag, ":ready_back"}, longint'(intf.in_ready), 1);
  endtask

  longint rn, rd, ra, rb;
  logic signed [15:0] d16;
  logic signed [17:0] a18;

  initial begin
    intf.in_valid  = 1'b0;
    intf.out_ready = 1'b0;
    intf.dividend  = '0;
    intf.divisor   = '0;
    #12;
    check("rst:out_valid", longint'(intf.out_valid), 0);
    check("rst:q", longint'(intf.quotient), 0);
    check("rst:r", longint'(intf.remainder), 0);
    check("rst:ovf", longint'(intf.ovf), 0);
    check("rst:div0", longint'(intf.div0), 0);
    check("rst:in_ready", longint'(intf.in_ready), 1);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    run_op("n21", -21, -3, 0);
    run_op("n7", -7, 2, 0);
    run_op("p7", 7, -2, 0);
    run_op("zero", 0, -5, 0);
    run_op("prodmin", 64'sd4294967296, -32768, 0);
    check("prodmin:q_exact", got_q, -131072);
    run_op("ovfpos", 64'sd4294967296, 1, 0);
    run_op("ovfneg", -64'sd8589934592, -1, 0);
    run_op("dz_pos", 100, 0, 0);
    run_op("dz_neg", -5, 0, 0);
    run_op("bp", 12345, 7, 10);
    for (int i = 0; i < 3; i++) begin
      @(posedge ap_clk);
      #1;
      check("bp:not_captured", longint'(intf.in_ready), 1);
    end

    // Abort an operation with reset at iteration 10 of the division loop.
    @(negedge ap_clk);
    intf.in_valid = 1'b1;
    intf.dividend = 34'sd1000;
    intf.divisor  = 16'sd7;
    @(posedge ap_clk);
    #1;
    intf.in_valid = 1'b0;
    repeat (10) @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("abort:out_valid", longint'(intf.out_valid), 0);
    check("abort:q", longint'(intf.quotient), 0);
    check("abort:r", longint'(intf.remainder), 0);
    check("abort:in_ready", longint'(intf.in_ready), 1);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    begin
      int stale = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge ap_clk);
        #1;
        if (intf.out_valid) stale++;
      end
      check("abort:no_stale", stale, 0);
    end
    run_op("post_rst", 6, 3, 0);

    for (int i = 0; i < 150; i++) begin
      if (i % 3 == 0) begin
        a18 = 18'($urandom);
        d16 = 16'($urandom);
        if (d16 == 0) d16 = 16'sd1;
        ra = a18; rb = d16;
        run_op("prod", ra * rb, rb, 0);
        check("prod:exact", got_q, ra);
      end else begin
        rn = {$urandom, $urandom};
        rn = (rn <<< 30) >>> 30;
        d16 = ($urandom_range(0, 9) == 0) ? 16'sd0 : 16'($urandom);
        if ($urandom_range(0, 1) == 1) d16 = d16 >>> $urandom_range(0, 14);
        rd = d16;
        run_op("rand", rn, rd, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
